// File: rtl/bram_arbiter_2p_if.sv
// Bus bundle between the two-requester BRAM arbiter, its two clients and the RAM macro.
// The slave view belongs to the arbiter; the master view is the clients plus the RAM.
interface bram_arbiter_2p_if #(
   parameter int P_DWIDTH = 32,
   parameter int P_EWIDTH = P_DWIDTH / 8,
   parameter int P_AWIDTH = 11
);
   logic                REQ0;
   logic                REQ1;
   logic [P_EWIDTH-1:0] WE0;
   logic [P_EWIDTH-1:0] WE1;
   logic [P_AWIDTH-1:0] ADDR0;
   logic [P_AWIDTH-1:0] ADDR1;
   logic [P_DWIDTH-1:0] WDATA0;
   logic [P_DWIDTH-1:0] WDATA1;
   logic                ACK0;
   logic                ACK1;
   logic                RVALID0;
   logic                RVALID1;
   logic [P_DWIDTH-1:0] RDATA0;
   logic [P_DWIDTH-1:0] RDATA1;
   logic                INIT_DONE;
   logic                MEM_EN;
   logic [P_EWIDTH-1:0] MEM_WE;
   logic [P_AWIDTH-1:0] MEM_ADDR;
   logic [P_DWIDTH-1:0] MEM_DIN;
   logic [P_DWIDTH-1:0] MEM_DOUT;

   modport slave (
      input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_DOUT,
      output ACK0, ACK1, RVALID0, RVALID1, RDATA0, RDATA1, INIT_DONE,
             MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN
   );

   modport master (
      output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_DOUT,
      input  ACK0, ACK1, RVALID0, RVALID1, RDATA0, RDATA1, INIT_DONE,
             MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN
   );
endinterface

// File: rtl/bram_arbiter_2p.sv
// Round-robin arbiter sharing one byte-enabled BRAM port between two requesters,
// with optional zero-fill after reset and fixed-latency read return.
module bram_arbiter_2p #(
   parameter int P_DWIDTH = 32,
   parameter int P_EWIDTH = P_DWIDTH / 8,
   parameter int P_AWIDTH = 11,
   parameter int P_RD_LAT = 1,
   parameter int P_INIT   = 1
) (
   input  logic            CLK,
   input  logic            RST,
   bram_arbiter_2p_if.slave bus
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t              ST_RESET = (P_INIT != 0) ? ST_INIT : ST_RUN;
   localparam logic [P_AWIDTH-1:0] CNT_LAST = '1;

   state_t              state_r, state_s;
   logic [P_AWIDTH-1:0] cnt_r, cnt_s;
   logic                last_r, last_s;
   logic [P_RD_LAT:0]   pipe_vld_r, pipe_vld_s;
   logic [P_RD_LAT:0]   pipe_own_r, pipe_own_s;
   logic                mem_en_r, mem_en_s;
   logic [P_EWIDTH-1:0] mem_we_r, mem_we_s;
   logic [P_AWIDTH-1:0] mem_addr_r, mem_addr_s;
   logic [P_DWIDTH-1:0] mem_din_r, mem_din_s;
   logic                ack0_r, ack0_s, ack1_r, ack1_s;
   logic                rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
   logic [P_DWIDTH-1:0] rdata0_r, rdata0_s, rdata1_r, rdata1_s;
   logic                init_done_r, init_done_s;
   logic                elig0_s, elig1_s, grant0_s, grant1_s, push_s;

   // Next-state: init sequencing, round-robin grant, read-return pipeline.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      last_s      = last_r;
      mem_en_s    = 1'b0;
      mem_we_s    = '0;
      mem_addr_s  = '0;
      mem_din_s   = '0;
      ack0_s      = 1'b0;
      ack1_s      = 1'b0;
      init_done_s = init_done_r;
      grant0_s    = 1'b0;
      grant1_s    = 1'b0;
      // A request whose ACK is showing this cycle is already issued.
      elig0_s     = bus.REQ0 & ~ack0_r;
      elig1_s     = bus.REQ1 & ~ack1_r;
      case (state_r)
         ST_INIT: begin
            mem_en_s   = 1'b1;
            mem_we_s   = '1;
            mem_addr_s = cnt_r;
            cnt_s      = cnt_r + P_AWIDTH'(1);
            if (cnt_r == CNT_LAST) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN: begin
            init_done_s = 1'b1;
            grant0_s    = elig0_s & (~elig1_s | last_r);
            grant1_s    = elig1_s & ~grant0_s;
            if (grant0_s) begin
               mem_en_s   = 1'b1;
               mem_we_s   = bus.WE0;
               mem_addr_s = bus.ADDR0;
               mem_din_s  = bus.WDATA0;
               ack0_s     = 1'b1;
               last_s     = 1'b0;
            end else if (grant1_s) begin
               mem_en_s   = 1'b1;
               mem_we_s   = bus.WE1;
               mem_addr_s = bus.ADDR1;
               mem_din_s  = bus.WDATA1;
               ack1_s     = 1'b1;
               last_s     = 1'b1;
            end else begin
               mem_en_s = 1'b0;
            end
         end
         default: begin
            state_s = ST_RESET;
         end
      endcase

      push_s     = (grant0_s | grant1_s) & (mem_we_s == '0);
      pipe_vld_s = {pipe_vld_r[P_RD_LAT-1:0], push_s};
      pipe_own_s = {pipe_own_r[P_RD_LAT-1:0], grant1_s};

      // The last stage lines up with MEM_DOUT being valid for that read.
      rvalid0_s = pipe_vld_r[P_RD_LAT] & ~pipe_own_r[P_RD_LAT];
      rvalid1_s = pipe_vld_r[P_RD_LAT] & pipe_own_r[P_RD_LAT];
      if (rvalid0_s) begin
         rdata0_s = bus.MEM_DOUT;
      end else begin
         rdata0_s = rdata0_r;
      end
      if (rvalid1_s) begin
         rdata1_s = bus.MEM_DOUT;
      end else begin
         rdata1_s = rdata1_r;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r     <= ST_RESET;
         cnt_r       <= '0;
         last_r      <= 1'b1;
         pipe_vld_r  <= '0;
         pipe_own_r  <= '0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= '0;
         mem_addr_r  <= '0;
         mem_din_r   <= '0;
         ack0_r      <= 1'b0;
         ack1_r      <= 1'b0;
         rvalid0_r   <= 1'b0;
         rvalid1_r   <= 1'b0;
         rdata0_r    <= '0;
         rdata1_r    <= '0;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         last_r      <= last_s;
         pipe_vld_r  <= pipe_vld_s;
         pipe_own_r  <= pipe_own_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_din_r   <= mem_din_s;
         ack0_r      <= ack0_s;
         ack1_r      <= ack1_s;
         rvalid0_r   <= rvalid0_s;
         rvalid1_r   <= rvalid1_s;
         rdata0_r    <= rdata0_s;
         rdata1_r    <= rdata1_s;
         init_done_r <= init_done_s;
      end
   end

   assign bus.ACK0      = ack0_r;
   assign bus.ACK1      = ack1_r;
   assign bus.RVALID0   = rvalid0_r;
   assign bus.RVALID1   = rvalid1_r;
   assign bus.RDATA0    = rdata0_r;
   assign bus.RDATA1    = rdata1_r;
   assign bus.INIT_DONE = init_done_r;
   assign bus.MEM_EN    = mem_en_r;
   assign bus.MEM_WE    = mem_we_r;
   assign bus.MEM_ADDR  = mem_addr_r;
   assign bus.MEM_DIN   = mem_din_r;

endmodule

// File: tb/tb_bram_arbiter_2p.sv
// Directed bench for bram_arbiter_2p: behavioural RAM, shadow memory and per-requester
// read scoreboards checked when RVALID pulses.
module tb_bram_arbiter_2p;
   localparam int DW = 32;
   localparam int EW = 4;
   localparam int AW = 11;
   localparam int DEPTH = 2048;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   bram_arbiter_2p_if #(.P_DWIDTH(DW), .P_EWIDTH(EW), .P_AWIDTH(AW)) bus ();

   bram_arbiter_2p #(
      .P_DWIDTH(DW), .P_EWIDTH(EW), .P_AWIDTH(AW), .P_RD_LAT(1), .P_INIT(1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   logic [DW-1:0] ram     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   int            l0[$];
   int            l1[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic [DW-1:0] ed0, ed1;
   int            ec0, ec1;

   // cycle counter
   always @(posedge CLK) cyc <= cyc + 1;

   // single-port RAM, one-cycle read latency
   always @(posedge CLK) begin
      if (bus.MEM_EN) begin
         if (bus.MEM_WE == '0) begin
            bus.MEM_DOUT <= ram[bus.MEM_ADDR];
         end else begin
            for (int b = 0; b < EW; b++) begin
               if (bus.MEM_WE[b]) ram[bus.MEM_ADDR][8*b +: 8] <= bus.MEM_DIN[8*b +: 8];
            end
         end
      end
   end

   // read-return monitor: expected latency from ACK, expected data from scoreboard
   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.ACK0 && bus.MEM_EN && bus.MEM_WE == '0) l0.push_back(cyc + 2);
         if (bus.ACK1 && bus.MEM_EN && bus.MEM_WE == '0) l1.push_back(cyc + 2);
         if (bus.RVALID0) begin
            n_tests++;
            assert (q0.size() > 0 && l0.size() > 0) else begin
               n_fail++; $error("FAIL rvalid0_expected observed=1 expected=0");
            end
            if (q0.size() > 0 && l0.size() > 0) begin
               ed0 = q0.pop_front();
               ec0 = l0.pop_front();
               n_tests++;
               assert (bus.RDATA0 === ed0) else begin
                  n_fail++; $error("FAIL rdata0 observed=%0h expected=%0h", bus.RDATA0, ed0);
               end
               n_tests++;
               assert (cyc === ec0) else begin
                  n_fail++; $error("FAIL rvalid0_cycle observed=%0d expected=%0d", cyc, ec0);
               end
            end
         end
         if (bus.RVALID1) begin
            n_tests++;
            assert (q1.size() > 0 && l1.size() > 0) else begin
               n_fail++; $error("FAIL rvalid1_expected observed=1 expected=0");
            end
            if (q1.size() > 0 && l1.size() > 0) begin
               ed1 = q1.pop_front();
               ec1 = l1.pop_front();
               n_tests++;
               assert (bus.RDATA1 === ed1) else begin
                  n_fail++; $error("FAIL rdata1 observed=%0h expected=%0h", bus.RDATA1, ed1);
               end
               n_tests++;
               assert (cyc === ec1) else begin
                  n_fail++; $error("FAIL rvalid1_cycle observed=%0d expected=%0d", cyc, ec1);
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [127:0] outs();
      return 128'({bus.ACK0, bus.ACK1, bus.RVALID0, bus.RVALID1, bus.RDATA0, bus.RDATA1,
                   bus.INIT_DONE, bus.MEM_EN, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN});
   endfunction

   // drive a command and update shadow memory / scoreboard
   task automatic present(input int r, input logic [EW-1:0] we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (r == 0) begin
         bus.REQ0 = 1'b1; bus.WE0 = we; bus.ADDR0 = a; bus.WDATA0 = d;
      end else begin
         bus.REQ1 = 1'b1; bus.WE1 = we; bus.ADDR1 = a; bus.WDATA1 = d;
      end
      if (we == '0) begin
         if (r == 0) q0.push_back(ref_mem[a]);
         else        q1.push_back(ref_mem[a]);
      end else begin
         for (int b = 0; b < EW; b++) begin
            if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic issue(input int r, input logic [EW-1:0] we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      int   lat;
      logic got;
      lat = 0;
      got = 1'b0;
      present(r, we, a, d);
      while (!got && lat < 20) begin
         tick();
         lat++;
         got = (r == 0) ? bus.ACK0 : bus.ACK1;
      end
      check("ack_latency", 128'(lat), 128'(1));
      if (r == 0) bus.REQ0 = 1'b0;
      else        bus.REQ1 = 1'b0;
      tick();
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((q0.size() + q1.size()) > 0 && w < 20) begin
         tick();
         w++;
      end
      check("drain", 128'(q0.size() + q1.size()), 128'(0));
   endtask

   task automatic tie(input logic [EW-1:0] we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [EW-1:0] we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      int c0, c1, w;
      c0 = -1; c1 = -1; w = 0;
      present(0, we0, a0, d0);
      present(1, we1, a1, d1);
      while ((c0 < 0 || c1 < 0) && w < 20) begin
         tick();
         w++;
         if (bus.ACK0) begin c0 = cyc; bus.REQ0 = 1'b0; end
         if (bus.ACK1) begin c1 = cyc; bus.REQ1 = 1'b0; end
      end
      tick();
      check("tie_both_acked", 128'({c0 >= 0, c1 >= 0}), 128'(2'b11));
      check("tie_req1_after_req0", 128'(c1 - c0), 128'(1));
   endtask

   initial begin
      int good, acks, i0, i1, en_cnt, first_en, last_en, alt_err, turn, w, rv;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = 32'hDEADBEEF;
         ref_mem[i] = 32'h0;
      end
      RST = 1'b1;
      bus.REQ0 = 1'b0; bus.WE0 = '0; bus.ADDR0 = '0; bus.WDATA0 = '0;
      bus.REQ1 = 1'b0; bus.WE1 = '0; bus.ADDR1 = '0; bus.WDATA1 = '0;
      repeat (3) tick();
      check("reset_outputs", outs(), 128'(0));

      // init fill, with a request held to show it is ignored
      bus.REQ0 = 1'b1;
      RST = 1'b0;
      good = 0; acks = 0;
      for (int c = 1; c <= DEPTH; c++) begin
         tick();
         if (bus.MEM_EN && bus.MEM_WE == 4'hF && bus.MEM_DIN == 32'h0 && bus.MEM_ADDR == AW'(c - 1))
            good++;
         if (bus.ACK0 || bus.ACK1) acks++;
         if (c == 2040) bus.REQ0 = 1'b0;
         if (c == DEPTH) check("init_done_early", 128'(bus.INIT_DONE), 128'(0));
      end
      check("init_writes", 128'(good), 128'(DEPTH));
      check("init_no_ack", 128'(acks), 128'(0));
      tick();
      check("init_done", 128'(bus.INIT_DONE), 128'(1));
      check("idle_after_init", 128'(bus.MEM_EN), 128'(0));

      issue(0, 4'h0, 11'h7FF, 32'h0);
      drain();

      // single requester write/read
      for (int i = 0; i < 4; i++) begin
         issue(0, 4'hF, AW'(i), 32'h44332211 + 32'(i) * 32'h11111111);
         issue(0, 4'h0, AW'(i), 32'h0);
         drain();
      end

      // preload via requester 1 (leaves requester 1 as last winner)
      for (int i = 6; i < 16; i++) issue(1, 4'hF, AW'(i), 32'hA5000000 | (32'(i) * 32'h00010101));

      tie(4'hF, 11'd1, 32'h11110001, 4'hF, 11'd2, 32'h22220002);
      tie(4'h0, 11'd1, 32'h0, 4'h0, 11'd2, 32'h0);
      drain();

      // byte enables
      issue(1, 4'hF, 11'd5, 32'hFFFFFFFF);
      issue(1, 4'b0101, 11'd5, 32'h0);
      issue(1, 4'h0, 11'd5, 32'h0);
      drain();
      check("byte_enable", 128'(bus.RDATA1), 128'(32'hFF00FF00));

      // saturation: 8 reads each, back-to-back
      i0 = 0; i1 = 0; en_cnt = 0; first_en = -1; last_en = -1; alt_err = 0; turn = 0; w = 0;
      present(0, 4'h0, 11'd0, 32'h0);
      present(1, 4'h0, 11'd8, 32'h0);
      while ((i0 < 8 || i1 < 8) && w < 60) begin
         tick();
         w++;
         if (bus.MEM_EN) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if ({bus.ACK0, bus.ACK1} != ((turn == 0) ? 2'b10 : 2'b01)) alt_err++;
            turn = 1 - turn;
         end
         if (bus.ACK0) begin
            i0++;
            if (i0 < 8) present(0, 4'h0, AW'(i0), 32'h0);
            else        bus.REQ0 = 1'b0;
         end
         if (bus.ACK1) begin
            i1++;
            if (i1 < 8) present(1, 4'h0, AW'(8 + i1), 32'h0);
            else        bus.REQ1 = 1'b0;
         end
      end
      check("sat_en_count", 128'(en_cnt), 128'(16));
      check("sat_en_span", 128'(last_en - first_en), 128'(15));
      check("sat_alternate", 128'(alt_err), 128'(0));
      drain();

      // reset one cycle after a read ACK
      issue(0, 4'h0, 11'd7, 32'h0);
      RST = 1'b1;
      q0.delete();
      l0.delete();
      #1;
      check("reset_mid_outputs", outs(), 128'(0));
      rv = 0;
      repeat (3) begin
         tick();
         rv = rv | int'(bus.RVALID0 | bus.RVALID1);
      end
      check("reset_hold_outputs", outs(), 128'(0));
      RST = 1'b0;
      tick();
      check("reinit_first", 128'({bus.MEM_EN, bus.MEM_WE, bus.MEM_ADDR, bus.INIT_DONE}),
            128'({1'b1, 4'hF, 11'd0, 1'b0}));
      tick();
      check("reinit_second_addr", 128'(bus.MEM_ADDR), 128'(1));
      repeat (5) begin
         tick();
         rv = rv | int'(bus.RVALID0 | bus.RVALID1);
      end
      check("reset_no_rvalid", 128'(rv), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
